mdu_ctrl: RTL

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_if.sv | 38 +++
 rtl/mdu_ctrl.sv | 119 +++++++++++
 2 files changed

// File: rtl/mdu_ctrl_if.sv
// Pipeline <-> mul/div controller bundle.
// master = pipeline/unit side, slave = mdu_ctrl.
interface mdu_ctrl_if;
    logic        flushE;
    logic        flush_exceptionM;
    logic        stallM;
    logic        op_valid;
    logic [1:0]  op_code;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [63:0] mul_result;
    logic [63:0] div_result;
    logic        div_done;
    logic        mul_ce;
    logic        mul_sign;
    logic        div_start;
    logic        div_sign;
    logic        div_abort;
    logic        stallE;
    logic        res_valid;
    logic [63:0] result;

    modport master (
        output flushE, flush_exceptionM, stallM, op_valid,
        output op_code, src_a, src_b,
        output mul_result, div_result, div_done,
        input  mul_ce, mul_sign, div_start, div_sign, div_abort,
        input  stallE, res_valid, result
    );

    modport slave (
        input  flushE, flush_exceptionM, stallM, op_valid,
        input  op_code, src_a, src_b,
        input  mul_result, div_result, div_done,
        output mul_ce, mul_sign, div_start, div_sign, div_abort,
        output stallE, res_valid, result
    );
endinterface

// File: rtl/mdu_ctrl.sv
// Mul/div sequencing controller for the EX stage.
// Optional macro MDU_DIVZERO_FAST_EN: divide-by-zero bypasses the divider.
module mdu_ctrl #(
    parameter int unsigned MUL_LAT = 9
) (
    input logic       clk,
    input logic       rst,
    mdu_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

`ifdef MDU_DIVZERO_FAST_EN
    localparam bit DZ_FAST = 1'b1;
`else
    localparam bit DZ_FAST = 1'b0;
`endif

    localparam logic [3:0] CNT_LAST = 4'(MUL_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] result_q, result_d;
    logic        mul_ce, div_start, div_abort;
    logic        issue, is_div, fast_zero, kill;

    assign issue     = bus.op_valid & ~bus.flushE;
    assign is_div    = bus.op_code[1];
    assign fast_zero = DZ_FAST & (bus.src_b == 32'h0);
    // Flush or the op vanishing from EX both abandon the operation.
    assign kill      = bus.flushE | ~bus.op_valid;

    // State, counter and result registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            result_q <= 64'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    // Next-state and unit-control decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        result_d  = result_q;
        mul_ce    = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (issue) begin
                    if (!is_div) begin
                        mul_ce  = 1'b1;
                        cnt_d   = 4'd1;
                        state_d = MUL;
                    end else if (fast_zero) begin
                        result_d = {bus.src_a, 32'hFFFF_FFFF};
                        state_d  = DONE;
                    end else begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end
                end
            end
            MUL: begin
                if (kill) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else begin
                    mul_ce = 1'b1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == CNT_LAST) begin
                        result_d = bus.mul_result;
                        cnt_d    = 4'd0;
                        state_d  = DONE;
                    end
                end
            end
            DIV: begin
                if (kill) begin
                    div_abort = 1'b1;
                    state_d   = IDLE;
                end else if (bus.div_done) begin
                    result_d = bus.div_result;
                    state_d  = DONE;
                end
            end
            DONE: begin
                cnt_d = 4'd0;
                if (bus.flushE || !bus.stallM) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = IDLE;
            end
        endcase
    end

    // Unit controls are forced low while reset is held.
    assign bus.mul_ce    = rst & mul_ce;
    assign bus.div_start = rst & div_start;
    assign bus.div_abort = rst & div_abort;
    assign bus.mul_sign  = rst & ~bus.op_code[1] & ~bus.op_code[0];
    assign bus.div_sign  = rst & bus.op_code[1] & ~bus.op_code[0];

    assign bus.stallE    = bus.op_valid & (state_q != DONE)
                         & ~bus.flush_exceptionM;
    assign bus.res_valid = (state_q == DONE);
    assign bus.result    = result_q;

endmodule
